// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and configuration checks for the hazard scoreboard
//
// Purpose: scoreboard entry layout, register-index type and the legality check
//          for the age/distance parameters used by hazard_scoreboard.
// Ports:   none (package).

package hazard_pkg;

   // Ages are 2 bits wide, so the retire age can be at most 3.
   localparam int SB_AGE_MAX = 3;

   typedef logic [1:0] sb_age_t;
   typedef logic [4:0] creg_addr_t;

   typedef struct packed {
      logic    busy;
      logic    is_load;
      sb_age_t age;
   } sb_entry_t;

   // An entry has to stay visible long enough to cover both hazard windows,
   // otherwise a consumer could slip past a writer that has not reached the regfile.
   function automatic bit sb_params_ok(input int load_use_dist,
                                       input int br_dist,
                                       input int wb_age,
                                       input int nsrc);
      return (wb_age > load_use_dist) && (wb_age > br_dist) &&
             (wb_age <= SB_AGE_MAX) && (load_use_dist >= 0) && (br_dist >= 0) &&
             (nsrc >= 2) && (nsrc <= 3);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one architectural register's in-flight writer record
//
// Purpose: holds {busy, is_load, age} for one register. A new issue always
//          replaces the current record (youngest writer wins), otherwise a busy
//          record ages and retires when it reaches WB_AGE.
// Ports:
//   clk, resetn    clock, async active-low reset
//   issue          a writer of this register leaves D this cycle
//   issue_load     that writer is a load
//   stall_e        E stage held (age-0 records do not advance)
//   stall_m        M stage held (age>=1 records do not advance)
//   busy, is_load  current record
//   age            current record age
//   retiring       record reaches WB_AGE at the coming edge

module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int WB_AGE = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       issue,
   input  logic       issue_load,
   input  logic       stall_e,
   input  logic       stall_m,
   output logic       busy,
   output logic       is_load,
   output logic [1:0] age,
   output logic       retiring
);

   localparam sb_age_t RETIRE_AGE = sb_age_t'(WB_AGE - 1);

   sb_entry_t ent;
   logic      advance;

   // Age 0 means the writer sits in E; from age 1 on it is in M or later,
   // so each half of the pipe freezes the record independently.
   assign advance  = (ent.age == 2'd0) ? ~stall_e : ~stall_m;
   assign retiring = ent.busy & advance & (ent.age == RETIRE_AGE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ent <= '0;
      end else if (issue) begin
         ent <= {1'b1, issue_load, 2'd0};
      end else if (retiring) begin
         ent <= '0;
      end else if (ent.busy && advance) begin
         ent.age <= ent.age + 2'd1;
      end
   end

   assign busy    = ent.busy;
   assign is_load = ent.is_load;
   assign age     = ent.age;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register scoreboard hazard unit for the F/D/E/M/W pipe
//
// Purpose: tracks in-flight writers per register and derives stall/flush for
//          load-use, branch-operand, memory-wait and multiply hazards.
// Optional feature: HAZARD_SB_STATS_EN adds saturating stall-cycle counters.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   i_data_ok, d_data_ok        ifetch / dmem response valid
//   mult_ok                     multiplier done (1 when idle)
//   branch_taken                D-stage redirect
//   d_rs, d_rs_used             D-stage sources {rsN..rs1} and their read enables
//   d_is_branch                 D instruction is a branch/jump
//   d_regwrite, d_memread, d_rd D instruction writes rd / is a load / destination
//   stallF..stallM              stage hold
//   flushD..flushW              stage bubble insert
//   stat_lw, stat_br, stat_mem  (HAZARD_SB_STATS_EN) stall-cycle counters

module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG          = 32,
   parameter int NSRC          = 2,
   parameter int LOAD_USE_DIST = 2,
   parameter int BR_DIST       = 1,
   parameter int WB_AGE        = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_data_ok,
   input  logic              d_data_ok,
   input  logic              mult_ok,
   input  logic              branch_taken,
   input  logic [NSRC*5-1:0] d_rs,
   input  logic [NSRC-1:0]   d_rs_used,
   input  logic              d_is_branch,
   input  logic              d_regwrite,
   input  logic              d_memread,
   input  logic [4:0]        d_rd,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              flushW
`ifdef HAZARD_SB_STATS_EN
   ,
   output logic [31:0]       stat_lw,
   output logic [31:0]       stat_br,
   output logic [31:0]       stat_mem
`endif
);

   if (!sb_params_ok(LOAD_USE_DIST, BR_DIST, WB_AGE, NSRC)) begin : g_bad_cfg
      $error("hazard_scoreboard: need WB_AGE > both distances, WB_AGE <= 3, NSRC in 2..3");
   end

   logic [NREG-1:0] sb_busy;
   logic [NREG-1:0] sb_load;
   logic [NREG-1:0] sb_retiring;
   logic [1:0]      sb_age [NREG];

   logic       raw_stall_e;
   logic       raw_stall_m;
   logic       issue_ok;
   logic       lwstall;
   logic       branchstall;
   logic       stall_fd;
   logic       flush_e_raw;
   creg_addr_t rs;
   logic       src_hit;
   int         src_age;

   // Pipe holds that do not depend on the scoreboard; the entries use them to
   // decide whether they advance this cycle.
   assign raw_stall_e = ~d_data_ok | ~mult_ok;
   assign raw_stall_m = ~d_data_ok;

   // x0 is hard-wired; it never has a writer in flight.
   assign sb_busy[0]     = 1'b0;
   assign sb_load[0]     = 1'b0;
   assign sb_retiring[0] = 1'b0;
   assign sb_age[0]      = 2'd0;

   for (genvar r = 1; r < NREG; r++) begin : g_entry
      hazard_sb_entry #(
         .WB_AGE (WB_AGE)
      ) u_entry (
         .clk        (clk),
         .resetn     (resetn),
         .issue      (issue_ok & d_regwrite & (d_rd == creg_addr_t'(r))),
         .issue_load (d_memread),
         .stall_e    (raw_stall_e),
         .stall_m    (raw_stall_m),
         .busy       (sb_busy[r]),
         .is_load    (sb_load[r]),
         .age        (sb_age[r]),
         .retiring   (sb_retiring[r])
      );
   end

   // Source checks. A record that retires at the coming edge is already
   // being written back, so the W->D bypass covers it and it is ignored.
   always_comb begin
      lwstall     = 1'b0;
      branchstall = 1'b0;
      rs          = '0;
      src_hit     = 1'b0;
      src_age     = 0;
      for (int s = 0; s < NSRC; s++) begin
         rs      = d_rs[s*5 +: 5];
         src_hit = d_rs_used[s] && (rs != '0) && (int'(rs) < NREG) &&
                   sb_busy[rs] && !sb_retiring[rs];
         src_age = int'(sb_age[rs]);
         if (src_hit && sb_load[rs] && (src_age < LOAD_USE_DIST)) begin
            lwstall = 1'b1;
         end
         if (src_hit && d_is_branch &&
             ((src_age < BR_DIST) || (sb_load[rs] && (src_age < LOAD_USE_DIST)))) begin
            branchstall = 1'b1;
         end
      end
   end

   assign stall_fd    = ~i_data_ok | ~d_data_ok | lwstall | branchstall | ~mult_ok;
   // A busy multiplier keeps E occupied, so E must not also be bubbled.
   assign flush_e_raw = (lwstall | branchstall | ~i_data_ok) & mult_ok;

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
      if (resetn) begin
         stallF = stall_fd;
         stallD = stall_fd;
         stallE = raw_stall_e;
         stallM = raw_stall_m;
         flushD = branch_taken & ~stall_fd;
         flushE = flush_e_raw;
         flushM = ~mult_ok;
         flushW = ~d_data_ok;
      end
   end

   // The D instruction moves into E only when D is released and E is not bubbled.
   assign issue_ok = ~stallD & ~flushE;

`ifdef HAZARD_SB_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_lw  <= '0;
         stat_br  <= '0;
         stat_mem <= '0;
      end else begin
         if (lwstall && (stat_lw != '1)) begin
            stat_lw <= stat_lw + 32'd1;
         end
         if (branchstall && (stat_br != '1)) begin
            stat_br <= stat_br + 32'd1;
         end
         if (!d_data_ok && (stat_mem != '1)) begin
            stat_mem <= stat_mem + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

   localparam int NREG = 32;
   localparam int NSRC = 2;
   localparam int LUD  = 2;
   localparam int BRD  = 1;
   localparam int WB   = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        i_data_ok = 1'b1;
   logic        d_data_ok = 1'b1;
   logic        mult_ok = 1'b1;
   logic        branch_taken = 1'b0;
   logic [9:0]  d_rs = '0;
   logic [1:0]  d_rs_used = '0;
   logic        d_is_branch = 1'b0;
   logic        d_regwrite = 1'b0;
   logic        d_memread = 1'b0;
   logic [4:0]  d_rd = '0;
   logic        stallF, stallD, stallE, stallM;
   logic        flushD, flushE, flushM, flushW;
   logic [7:0]  dut_vec;
`ifdef HAZARD_SB_STATS_EN
   logic [31:0] stat_lw, stat_br, stat_mem;
   logic [31:0] m_lw = '0, m_br = '0, m_mem = '0;
`endif

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(
      .NREG(NREG), .NSRC(NSRC), .LOAD_USE_DIST(LUD), .BR_DIST(BRD), .WB_AGE(WB)
   ) dut (
      .clk(clk), .resetn(resetn), .i_data_ok(i_data_ok), .d_data_ok(d_data_ok),
      .mult_ok(mult_ok), .branch_taken(branch_taken), .d_rs(d_rs), .d_rs_used(d_rs_used),
      .d_is_branch(d_is_branch), .d_regwrite(d_regwrite), .d_memread(d_memread), .d_rd(d_rd),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW)
`ifdef HAZARD_SB_STATS_EN
      , .stat_lw(stat_lw), .stat_br(stat_br), .stat_mem(stat_mem)
`endif
   );

   always #5 clk = ~clk;

   assign dut_vec = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};

   // Reference: list of in-flight writers in issue order; a source looks up its
   // youngest writer. Records leave the list once their age reaches WB.
   typedef struct {
      int rd;
      bit ld;
      int age;
   } rec_t;

   rec_t sb_q[$];
   rec_t nq[$];
   rec_t nr;
   bit   u_lw, u_br, c_lw, c_br;
   logic [7:0] u_o, c_o;

   function automatic logic [7:0] model_out(output bit lw, output bit br);
      bit se, sm, sfd;
      int rs;
      lw = 0;
      br = 0;
      se = !d_data_ok || !mult_ok;
      sm = !d_data_ok;
      for (int s = 0; s < NSRC; s++) begin
         rs = int'(d_rs[s*5 +: 5]);
         if (d_rs_used[s] && rs != 0) begin
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
               if (sb_q[i].rd == rs) begin
                  int  a;
                  bit  ret;
                  a   = sb_q[i].age;
                  ret = (a == WB - 1) && ((a == 0) ? !se : !sm);
                  if (!ret) begin
                     if (sb_q[i].ld && a < LUD) lw = 1;
                     if (d_is_branch && (a < BRD || (sb_q[i].ld && a < LUD))) br = 1;
                  end
                  break;
               end
            end
         end
      end
      sfd = !i_data_ok || !d_data_ok || lw || br || !mult_ok;
      if (!resetn) return 8'b0000_1111;
      return {sfd, sfd, se, sm, branch_taken && !sfd, (lw || br || !i_data_ok) && mult_ok,
              !mult_ok, !d_data_ok};
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sb_q.delete();
`ifdef HAZARD_SB_STATS_EN
         m_lw = '0; m_br = '0; m_mem = '0;
`endif
      end else begin
         u_o = model_out(u_lw, u_br);
         nq.delete();
         foreach (sb_q[i]) begin
            nr = sb_q[i];
            if ((nr.age == 0) ? !u_o[5] : !u_o[4]) nr.age++;
            if (nr.age < WB) nq.push_back(nr);
         end
         if (!u_o[6] && !u_o[2] && d_regwrite && d_rd != 5'd0) begin
            nr.rd  = int'(d_rd);
            nr.ld  = d_memread;
            nr.age = 0;
            nq.push_back(nr);
         end
         sb_q = nq;
`ifdef HAZARD_SB_STATS_EN
         if (u_lw && m_lw != 32'hFFFF_FFFF) m_lw++;
         if (u_br && m_br != 32'hFFFF_FFFF) m_br++;
         if (!d_data_ok && m_mem != 32'hFFFF_FFFF) m_mem++;
`endif
      end
   end

   always @(negedge clk) begin
      c_o = model_out(c_lw, c_br);
      checks++;
      if (dut_vec !== c_o) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, dut_vec, c_o);
      end
`ifdef HAZARD_SB_STATS_EN
      checks++;
      if ({stat_lw, stat_br, stat_mem} !== {m_lw, m_br, m_mem}) begin
         errors++;
         $display("FAIL stats t=%0t got=%0d/%0d/%0d expected=%0d/%0d/%0d", $time,
                  stat_lw, stat_br, stat_mem, m_lw, m_br, m_mem);
      end
`endif
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic dins(input int r1, input int r2, input logic [1:0] used, input bit br,
                       input bit rw, input bit mr, input int rd);
      d_rs        = {5'(r2), 5'(r1)};
      d_rs_used   = used;
      d_is_branch = br;
      d_regwrite  = rw;
      d_memread   = mr;
      d_rd        = 5'(rd);
   endtask

   task automatic idle_gap;
      dins(0, 0, 2'b00, 0, 0, 0, 0);
      repeat (4) next_cyc;
   endtask

   initial begin
      @(negedge clk);
      chk("reset_outputs", dut_vec, 8'b0000_1111);
      next_cyc;
      resetn = 1'b1;
      @(negedge clk);
      chk("post_reset_quiet", dut_vec, 8'b0000_0000);
      next_cyc;

      // load-use: ld x5 then add x6,x5,x1 stalls two cycles
      dins(0, 0, 2'b00, 0, 1, 1, 5);
      @(negedge clk); chk("t1_ld_issues", stallD, 1'b0); next_cyc;
      dins(5, 1, 2'b11, 0, 1, 0, 6);
      @(negedge clk); chk("t1_lw_age0", {stallD, flushE}, 2'b11); next_cyc;
      @(negedge clk); chk("t1_lw_age1", {stallD, flushE}, 2'b11); next_cyc;
      @(negedge clk); chk("t1_consumer_issues", {stallD, flushE}, 2'b00); next_cyc;
      idle_gap;

      // branch operand: addi x7 then beq x7,x0 stalls one cycle
      dins(0, 0, 2'b00, 0, 1, 0, 7);
      @(negedge clk); next_cyc;
      dins(7, 0, 2'b11, 1, 0, 0, 0);
      @(negedge clk); chk("t2_br_stall", {stallD, flushE}, 2'b11); next_cyc;
      branch_taken = 1'b1;
      @(negedge clk); chk("t2_br_released_redirect", {stallD, flushD}, 2'b01); next_cyc;
      branch_taken = 1'b0;
      idle_gap;

      // youngest writer wins: ld x5 then addi x5, reader of x5 sees a non-load
      dins(0, 0, 2'b00, 0, 1, 1, 5);
      @(negedge clk); next_cyc;
      dins(0, 0, 2'b00, 0, 1, 0, 5);
      @(negedge clk); chk("t3_overwrite_issues", stallD, 1'b0); next_cyc;
      dins(5, 0, 2'b01, 0, 1, 0, 9);
      @(negedge clk); chk("t3_no_lwstall", {stallD, flushE}, 2'b00); next_cyc;
      idle_gap;

      // multiply in E held by mult_ok=0; its record stays at age 0
      dins(0, 0, 2'b00, 0, 1, 0, 8);
      @(negedge clk); next_cyc;
      mult_ok = 1'b0;
      dins(8, 0, 2'b01, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("t4_mul_busy_%0d", k), {stallE, flushM, flushE, stallD}, 4'b1101);
         next_cyc;
      end
      mult_ok = 1'b1;
      @(negedge clk); chk("t4_age_still0", {stallD, flushE}, 2'b11); next_cyc;
      @(negedge clk); chk("t4_br_released", {stallD, flushE}, 2'b00); next_cyc;
      idle_gap;

      // dmem wait with a load at age 1: age frozen, lwstall held
      dins(0, 0, 2'b00, 0, 1, 1, 10);
      @(negedge clk); next_cyc;
      dins(0, 0, 2'b00, 0, 0, 0, 0);
      @(negedge clk); next_cyc;
      d_data_ok = 1'b0;
      dins(10, 0, 2'b01, 0, 1, 0, 11);
      @(negedge clk); chk("t5_wait_0", {stallM, flushW, stallD, flushE, flushM}, 5'b11110); next_cyc;
      mult_ok = 1'b0;
      @(negedge clk); chk("t5_wait_mul", {stallM, flushW, stallD, flushE, flushM}, 5'b11101); next_cyc;
      mult_ok = 1'b1;
      @(negedge clk); chk("t5_wait_2", {stallM, flushW, stallD, flushE, flushM}, 5'b11110); next_cyc;
      d_data_ok = 1'b1;
      @(negedge clk); chk("t5_age_frozen", {stallD, flushE}, 2'b11); next_cyc;
      @(negedge clk); chk("t5_released", {stallD, flushE}, 2'b00); next_cyc;
      idle_gap;

      // reset with three loads in flight
      dins(0, 0, 2'b00, 0, 1, 1, 11); @(negedge clk); next_cyc;
      dins(0, 0, 2'b00, 0, 1, 1, 12); @(negedge clk); next_cyc;
      dins(0, 0, 2'b00, 0, 1, 1, 13); @(negedge clk); next_cyc;
      dins(11, 12, 2'b11, 0, 0, 0, 0);
      resetn = 1'b0;
      @(negedge clk); chk("t6_in_reset", dut_vec, 8'b0000_1111); next_cyc;
      resetn = 1'b1;
      @(negedge clk); chk("t6_no_lw_after_reset", dut_vec, 8'b0000_0000); next_cyc;
      dins(13, 0, 2'b01, 1, 0, 0, 0);
      @(negedge clk); chk("t6_no_br_after_reset", dut_vec, 8'b0000_0000);
`ifdef HAZARD_SB_STATS_EN
      chk("t6_stats_zero", {stat_lw | stat_br | stat_mem}, 32'd0);
`endif
      next_cyc;

      // randomized traffic, checked every cycle by the compare process
      for (int n = 0; n < 3000; n++) begin
         resetn       = ($urandom_range(0, 199) != 0);
         i_data_ok    = ($urandom_range(0, 9) != 0);
         d_data_ok    = ($urandom_range(0, 6) != 0);
         mult_ok      = ($urandom_range(0, 6) != 0);
         branch_taken = ($urandom_range(0, 9) == 0);
         dins(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
              int'($urandom_range(0, 7)));
         next_cyc;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
